uart_tx_fifo: RTL and testbench

- Buffered UART transmitter for host-to-line traffic; the send-side counterpart to the team's receive path.
- Accepts bytes over a valid/ready handshake into an internal FIFO and serialises them LSB-first.
- Frame format: 1 start bit, 8 data bits, optional parity, 1 or 2 stop bits.
- Consecutive frames go out back-to-back with no idle gap while the FIFO holds data.

---
 rtl/uart_tx_fifo.sv | 209 ++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: a byte FIFO feeding an LSB-first serialiser (start, 8 data, opt. parity, 1-2 stop).
// Write-to-start-bit latency is 2 cycles from empty; tx_ready = !full, so a full FIFO stalls the source.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_AW      = 3,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tx_valid,
    input  logic [7:0]       tx_data,
    output logic             tx_ready,
    output logic             tx,
    output logic             busy,
    output logic [FIFO_AW:0] fifo_count,
    output logic             tx_done
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CW    = $clog2(CLKS_PER_BIT);

    localparam logic [CW-1:0]    CNT_MAX   = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]    CNT_ONE   = CW'(1);
    localparam logic [FIFO_AW:0] CNT_FULL  = {1'b1, {FIFO_AW{1'b0}}};
    localparam logic             PAR_ON    = (PARITY_EN != 0);
    localparam logic             ODD_BIT   = (PARITY_ODD != 0);
    localparam logic             LAST_STOP = (STOP_BITS == 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    logic [7:0]         mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]   count_q, count_d;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2:0]         bit_idx_q, bit_idx_d;
    logic               stop_idx_q, stop_idx_d;
    logic [7:0]         shift_q, shift_d;
    logic               par_q, par_d;
    logic               tx_q, tx_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;

    logic push;
    logic pop;
    logic fifo_nonempty;
    logic bit_end;

    // Ready is taken from the registered count, so a same-cycle pop cannot reopen a full FIFO.
    assign tx_ready      = !rst && (count_q != CNT_FULL);
    assign push          = tx_valid && tx_ready;
    assign fifo_nonempty = (count_q != '0);
    assign bit_end       = (cnt_q == '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        shift_d    = shift_q;
        par_d      = par_q;
        tx_d       = tx_q;
        done_d     = 1'b0;
        pop        = 1'b0;

        // Every non-idle state runs the bit timer; a bit ends when it reads zero.
        if (state_q != S_IDLE) begin
            cnt_d = bit_end ? CNT_MAX : (cnt_q - CNT_ONE);
        end

        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (fifo_nonempty) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    par_d   = 1'b0;
                    cnt_d   = CNT_MAX;
                    tx_d    = 1'b0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    bit_idx_d = 3'd0;
                    tx_d      = shift_q[0];
                    state_d   = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    shift_d   = {1'b0, shift_q[7:1]};
                    par_d     = par_q ^ shift_q[0];
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q != 3'd7) begin
                        tx_d = shift_q[1];
                    end else if (PAR_ON) begin
                        tx_d    = par_q ^ shift_q[0] ^ ODD_BIT;
                        state_d = S_PARITY;
                    end else begin
                        tx_d       = 1'b1;
                        stop_idx_d = 1'b0;
                        state_d    = S_STOP;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    tx_d       = 1'b1;
                    stop_idx_d = 1'b0;
                    state_d    = S_STOP;
                end
            end
            S_STOP: begin
                // Raised one cycle early so the registered pulse lands on the last stop cycle.
                if ((stop_idx_q == LAST_STOP) && (cnt_q == CNT_ONE)) begin
                    done_d = 1'b1;
                end
                if (bit_end) begin
                    if (stop_idx_q != LAST_STOP) begin
                        stop_idx_d = 1'b1;
                    end else if (fifo_nonempty) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        par_d   = 1'b0;
                        tx_d    = 1'b0;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE) || (count_d != '0);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= tx_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            tx_q       <= 1'b1;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            tx_q       <= tx_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

    assign tx         = tx_q;
    assign tx_done    = done_q;
    assign busy       = busy_q;
    assign fifo_count = count_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Three transmitter configurations (8N1, 8E2, 8O2) at 4 clocks/bit, checked by a line-level scoreboard.
module tb_uart_tx_fifo;
    localparam int CPB = 4;

    typedef struct {
        int         k;
        logic [7:0] b;
        int         c;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] vld = '0;
    logic [7:0] dat [3];
    logic [2:0] rdy_w, tx_w, busy_w, done_w;
    logic [3:0] cnt_w [3];

    int   cyc   = 0;
    int   nvec  = 0;
    int   nfail = 0;
    exp_t sbq [$];

    bit          in_frame [3];
    int          fstart   [3];
    int          nb       [3];
    int          ndone    [3];
    int          last_end [3];
    logic [11:0] ebits    [3];

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_AW(3), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_n1 (
        .clk(clk), .rst(rst), .tx_valid(vld[0]), .tx_data(dat[0]), .tx_ready(rdy_w[0]),
        .tx(tx_w[0]), .busy(busy_w[0]), .fifo_count(cnt_w[0]), .tx_done(done_w[0]));
    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_AW(3), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u_e2 (
        .clk(clk), .rst(rst), .tx_valid(vld[1]), .tx_data(dat[1]), .tx_ready(rdy_w[1]),
        .tx(tx_w[1]), .busy(busy_w[1]), .fifo_count(cnt_w[1]), .tx_done(done_w[1]));
    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_AW(3), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u_o2 (
        .clk(clk), .rst(rst), .tx_valid(vld[2]), .tx_data(dat[2]), .tx_ready(rdy_w[2]),
        .tx(tx_w[2]), .busy(busy_w[2]), .fifo_count(cnt_w[2]), .tx_done(done_w[2]));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int k, input int act, input int exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            if (nfail <= 40) $display("FAIL %s dut%0d cycle %0d: got %0d, expected %0d", name, k, cyc, act, exp);
        end
    endtask

    // Reference frame: start 0, data LSB first, parity = XOR of data (inverted for odd), then stop 1s.
    function automatic void frame_bits(input int k, input logic [7:0] b, output logic [11:0] bits, output int n);
        int pen;
        int podd;
        int nstop;
        pen   = (k != 0) ? 1 : 0;
        podd  = (k == 2) ? 1 : 0;
        nstop = (k == 0) ? 1 : 2;
        bits  = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[1 + i] = b[i];
        n = 9;
        if (pen != 0) begin
            bits[9] = (^b) ^ (podd != 0);
            n = 10;
        end
        n = n + nstop;
    endfunction

    int   idx, off, exp_start;
    exp_t e;

    // Monitor: pops the scoreboard when a start bit appears, then checks every cycle of the frame.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                in_frame[k] = 1'b0;
                check("tx_high_in_reset", k, int'(tx_w[k]), 1);
            end else begin
                if (!in_frame[k] && tx_w[k] == 1'b0) begin
                    idx = -1;
                    foreach (sbq[i]) if (idx < 0 && sbq[i].k == k) idx = i;
                    check("frame_expected", k, int'(idx >= 0), 1);
                    if (idx >= 0) begin
                        e = sbq[idx];
                        sbq.delete(idx);
                        exp_start = (e.c + 2 > last_end[k] + 1) ? e.c + 2 : last_end[k] + 1;
                        check("frame_start_cycle", k, cyc, exp_start);
                        frame_bits(k, e.b, ebits[k], nb[k]);
                        fstart[k]   = cyc;
                        in_frame[k] = 1'b1;
                    end
                end
                if (in_frame[k]) begin
                    off = cyc - fstart[k];
                    check("line_bit", k, int'(tx_w[k]), int'(ebits[k][off / CPB]));
                    check("done_pulse", k, int'(done_w[k]), int'(off == nb[k] * CPB - 1));
                    if (off == nb[k] * CPB - 1) begin
                        in_frame[k] = 1'b0;
                        last_end[k] = cyc;
                    end
                end else begin
                    check("done_while_idle", k, int'(done_w[k]), 0);
                end
            end
            if (done_w[k]) ndone[k]++;
        end
        for (int k = 0; k < 3; k++) begin
            if (!rst && vld[k] && rdy_w[k]) begin
                e.k = k;
                e.b = dat[k];
                e.c = cyc;
                sbq.push_back(e);
            end
        end
    end

    // Holds valid until accepted; n returns the cycle of the write.
    task automatic push(input int k, input logic [7:0] b, output int n);
        int t;
        t = 0;
        vld[k] = 1'b1;
        dat[k] = b;
        @(negedge clk);
        while (!rdy_w[k] && t < 4000) begin
            @(negedge clk);
            t++;
        end
        check("push_wait_bound", k, int'(t < 4000), 1);
        n = cyc;
        @(posedge clk);
        #1;
        vld[k] = 1'b0;
    endtask

    task automatic wait_cyc(input int c);
        do @(negedge clk); while (cyc < c);
    endtask

    task automatic drain();
        int g;
        g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (busy_w != 3'b000 && g < 6000);
        check("drain_bound", -1, int'(g < 6000), 1);
        check("scoreboard_empty", -1, sbq.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic rand_traffic(input int k, input int nbytes);
        int n;
        int g;
        for (int i = 0; i < nbytes; i++) begin
            g = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 70)) : int'($urandom_range(0, 2));
            repeat (g) begin
                @(posedge clk);
                #1;
            end
            push(k, 8'($urandom_range(0, 255)), n);
        end
    endtask

    initial begin
        int n, n1, n2, n10, lows, d0, g;
        for (int k = 0; k < 3; k++) begin
            dat[k] = '0;
            last_end[k] = -100;
            ndone[k] = 0;
        end

        // Reset and idle
        repeat (5) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) check("ready_in_reset", k, int'(rdy_w[k]), 0);
        rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check("idle_tx", k, int'(tx_w[k]), 1);
            check("idle_ready", k, int'(rdy_w[k]), 1);
            check("idle_busy", k, int'(busy_w[k]), 0);
            check("idle_count", k, int'(cnt_w[k]), 0);
        end
        lows = 0;
        repeat (100) begin
            @(negedge clk);
            lows += (tx_w != 3'b111) ? 1 : 0;
        end
        check("idle_no_activity", -1, lows, 0);
        @(posedge clk);
        #1;

        // Single byte on 8N1
        push(0, 8'hA5, n);
        wait_cyc(n + 1);
        check("count_after_write", 0, int'(cnt_w[0]), 1);
        check("tx_before_start", 0, int'(tx_w[0]), 1);
        wait_cyc(n + 2);
        check("start_at_n2", 0, int'(tx_w[0]), 0);
        wait_cyc(n + 41);
        check("a5_done_at_n41", 0, int'(done_w[0]), 1);
        check("a5_busy_at_n41", 0, int'(busy_w[0]), 1);
        wait_cyc(n + 42);
        check("a5_busy_low_n42", 0, int'(busy_w[0]), 0);
        drain();

        // Parity and two stop bits
        push(1, 8'h07, n1);
        push(2, 8'h07, n2);
        push(1, 8'h03, n);
        push(2, 8'h03, n);
        wait_cyc(n1 + 49);
        check("even_12bit_done", 1, int'(done_w[1]), 1);
        wait_cyc(n2 + 49);
        check("odd_12bit_done", 2, int'(done_w[2]), 1);
        drain();

        // Burst into a full FIFO
        d0 = ndone[0];
        push(0, 8'h00, n1);
        for (int b = 1; b < 9; b++) push(0, 8'(b), n);
        fork
            push(0, 8'h09, n10);
            begin
                wait_cyc(n1 + 9);
                check("full_ready_low", 0, int'(rdy_w[0]), 0);
                check("full_count", 0, int'(cnt_w[0]), 8);
                wait_cyc(n1 + 41);
                check("ready_low_on_pop", 0, int'(rdy_w[0]), 0);
            end
        join
        check("stall_release_cycle", 0, n10, n1 + 42);
        drain();
        check("burst_done_pulses", 0, ndone[0] - d0, 10);

        // Push and pop in the same cycle
        for (int b = 0; b < 4; b++) push(0, 8'h11 + 8'(b), n);
        g = 0;
        do begin
            @(posedge clk);
            #1;
            g++;
        end while (!done_w[0] && g < 200);
        check("done_wait_bound", 0, int'(g < 200), 1);
        vld[0] = 1'b1;
        dat[0] = 8'h15;
        @(negedge clk);
        check("count_before_pushpop", 0, int'(cnt_w[0]), 3);
        @(posedge clk);
        #1;
        vld[0] = 1'b0;
        @(negedge clk);
        check("count_after_pushpop", 0, int'(cnt_w[0]), 3);
        drain();

        // Reset during data bit 3 with four bytes queued
        for (int b = 0; b < 5; b++) begin
            push(0, 8'h21 + 8'(b), n);
            if (b == 0) n1 = n;
        end
        wait_cyc(n1 + 19);
        check("pre_reset_count", 0, int'(cnt_w[0]), 4);
        check("pre_reset_bit3", 0, int'(tx_w[0]), 0);
        #2;
        rst = 1'b1;
        sbq.delete();
        #1;
        check("async_reset_tx", 0, int'(tx_w[0]), 1);
        check("async_reset_count", 0, int'(cnt_w[0]), 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        d0 = ndone[0];
        lows = 0;
        repeat (200) begin
            @(negedge clk);
            lows += (tx_w != 3'b111) ? 1 : 0;
        end
        check("no_residual_frame", 0, lows, 0);
        check("no_residual_done", 0, ndone[0] - d0, 0);
        @(posedge clk);
        #1;

        // Randomised traffic on all three
        fork
            rand_traffic(0, 25);
            rand_traffic(1, 25);
            rand_traffic(2, 25);
        join
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

    initial begin
        #500000;
        nfail++;
        $display("FAIL watchdog: run did not complete, cycle %0d", cyc);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
